// File: rtl/l1_dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Hits complete in the issuing cycle; misses run an optional writeback, then a line refill.
module l1_dcache_ctrl #(
    parameter int LINES     = 16,
    parameter int WORDS     = 4,
    parameter int ADDR_BITS = 12
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_ren,
    input  logic        cpu_wen,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_din,
    output logic [31:0] cpu_dout,
    output logic        cpu_stall,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int OFF = $clog2(WORDS);
    localparam int IDX = $clog2(LINES);
    localparam int TAG = ADDR_BITS - IDX - OFF;
    localparam logic [OFF-1:0] CNT_LAST = OFF'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, WB, REFILL} state_t;

    state_t                 state_q, state_d;
    logic [OFF-1:0]         cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]   miss_addr_q, miss_addr_d;
    logic [31:0]            hit_count_q, hit_count_d;
    logic [31:0]            miss_count_q, miss_count_d;
    logic [LINES-1:0]       valid_q;
    logic [LINES-1:0]       dirty_q;
    logic [TAG-1:0]         tag_q  [LINES];
    logic [31:0]            data_q [LINES][WORDS];

    logic [OFF-1:0] cpu_off;
    logic [IDX-1:0] cpu_idx, m_idx;
    logic [TAG-1:0] cpu_tag, m_tag;
    logic           req, hit;
    logic           store_hit, refill_we, refill_done, wb_done;
    logic           unused_addr_bits;

    assign cpu_off = cpu_addr[OFF-1:0];
    assign cpu_idx = cpu_addr[OFF+IDX-1:OFF];
    assign cpu_tag = cpu_addr[ADDR_BITS-1:OFF+IDX];
    assign m_idx   = miss_addr_q[OFF+IDX-1:OFF];
    assign m_tag   = miss_addr_q[ADDR_BITS-1:OFF+IDX];
    assign unused_addr_bits = ^{cpu_addr[31:ADDR_BITS], miss_addr_q[OFF-1:0]};

    assign req        = cpu_ren | cpu_wen;
    assign hit        = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
    assign cpu_dout   = data_q[cpu_idx][cpu_off];
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        miss_addr_d  = miss_addr_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        cpu_stall    = 1'b0;
        mem_ren      = 1'b0;
        mem_wen      = 1'b0;
        mem_addr     = 32'd0;
        mem_din      = 32'd0;
        store_hit    = 1'b0;
        refill_we    = 1'b0;
        refill_done  = 1'b0;
        wb_done      = 1'b0;
        case (state_q)
            IDLE: begin
                // Reset forces the stall low even with a request pending.
                cpu_stall = reset & req & ~hit;
                if (req && hit) begin
                    hit_count_d = hit_count_q + 32'd1;
                    store_hit   = cpu_wen;
                end else if (req) begin
                    miss_count_d = miss_count_q + 32'd1;
                    miss_addr_d  = cpu_addr[ADDR_BITS-1:0];
                    cnt_d        = '0;
                    state_d      = (valid_q[cpu_idx] && dirty_q[cpu_idx]) ? WB : REFILL;
                end
            end
            WB: begin
                cpu_stall = 1'b1;
                mem_wen   = 1'b1;
                mem_addr  = {{(32-ADDR_BITS){1'b0}}, tag_q[m_idx], m_idx, cnt_q};
                mem_din   = data_q[m_idx][cnt_q];
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    wb_done = 1'b1;
                    cnt_d   = '0;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                cpu_stall = 1'b1;
                mem_ren   = 1'b1;
                mem_addr  = {{(32-ADDR_BITS){1'b0}}, m_tag, m_idx, cnt_q};
                refill_we = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    refill_done = 1'b1;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            miss_addr_q  <= '0;
            hit_count_q  <= 32'd0;
            miss_count_q <= 32'd0;
            valid_q      <= '0;
            dirty_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            miss_addr_q  <= miss_addr_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            if (store_hit)
                dirty_q[cpu_idx] <= 1'b1;
            if (wb_done || refill_done)
                dirty_q[m_idx] <= 1'b0;
            if (refill_done)
                valid_q[m_idx] <= 1'b1;
        end
    end

    // Tag and data storage are deliberately left uninitialised by reset.
    always_ff @(posedge clock) begin
        if (store_hit)
            data_q[cpu_idx][cpu_off] <= cpu_din;
        if (refill_we)
            data_q[m_idx][cnt_q] <= mem_dout;
        if (refill_done)
            tag_q[m_idx] <= m_tag;
    end
endmodule
